imem_loader: RTL and testbench

//   Write side of the instruction memory: receives a byte-serial program image,

---
 rtl/imem_loader.sv | 201 ++++++++++++++++++++
 tb/tb_imem_loader.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader
//   Write side of the instruction memory. Receives a byte-serial program
//   image (LEN_HI, LEN_LO, 4*N data bytes, CHK) and packs the data bytes
//   big-endian into 32-bit words. Each word is written to instruction
//   memory with a single-cycle strobe. The CPU core is held in reset until
//   a whole frame has loaded and its XOR checksum matches.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      re-arm pulse, honoured only after a frame has finished (done or error)
//   in_valid   byte link: in_data is valid
//   in_data    byte link: data byte
//   in_ready   byte link: a byte is accepted this cycle (combinational, state only)
//   mem_we     instruction memory write strobe, one cycle per word
//   mem_addr   byte address of the write (holds when mem_we=0)
//   mem_wdata  instruction word to write (holds when mem_we=0)
//   cpu_hold   1 = core held in reset
//   done       frame loaded and checksum OK (sticky)
//   error      frame rejected (sticky)
module imem_loader #(
  parameter int          ADDR_WIDTH = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_CHK,
    S_DONE,
    S_ERR
  } state_t;

  localparam int          WIDX_W    = ADDR_WIDTH + 1;
  localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_WIDTH;

  state_t              state_q, state_d;
  logic [7:0]          len_hi_q, len_hi_d;
  logic [15:0]         len_q, len_d;
  logic [1:0]          byte_idx_q, byte_idx_d;
  logic [WIDX_W-1:0]   word_idx_q, word_idx_d;
  logic [7:0]          xor_q, xor_d;
  logic [23:0]         part_q, part_d;
  logic                mem_we_q, mem_we_d;
  logic [31:0]         mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic                hold_q, hold_d;
  logic                accept;
  logic [15:0]         len_now;

  assign in_ready = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                    (state_q == S_DATA)   || (state_q == S_CHK);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    len_hi_d    = len_hi_q;
    len_d       = len_q;
    byte_idx_d  = byte_idx_q;
    word_idx_d  = word_idx_q;
    xor_d       = xor_q;
    part_d      = part_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    done_d      = done_q;
    error_d     = error_q;
    hold_d      = hold_q;
    len_now     = {len_hi_q, in_data};

    case (state_q)
      S_LEN_HI: begin
        if (accept) begin
          len_hi_d = in_data;
          xor_d    = xor_q ^ in_data;
          state_d  = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (accept) begin
          len_d      = len_now;
          xor_d      = xor_q ^ in_data;
          word_idx_d = '0;
          byte_idx_d = '0;
          if (len_now == 16'd0) begin
            state_d = S_CHK;
          end else if ({1'b0, len_now} > MAX_WORDS) begin
            state_d = S_ERR;
            error_d = 1'b1;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          xor_d = xor_q ^ in_data;
          if (byte_idx_q == 2'd3) begin
            // The completed word and its address are registered together, so the
            // strobe appears the cycle after the 4th byte with both already stable.
            mem_wdata_d = {part_q, in_data};
            mem_addr_d  = BASE_ADDR + (32'(word_idx_q) << 2);
            mem_we_d    = 1'b1;
            word_idx_d  = word_idx_q + 1'b1;
            byte_idx_d  = '0;
            part_d      = '0;
            if (17'(word_idx_q) + 17'd1 == {1'b0, len_q}) begin
              state_d = S_CHK;
            end
          end else begin
            part_d     = {part_q[15:0], in_data};
            byte_idx_d = byte_idx_q + 1'b1;
          end
        end
      end
      S_CHK: begin
        if (accept) begin
          if (in_data == xor_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            hold_d  = 1'b0;
          end else begin
            state_d = S_ERR;
            error_d = 1'b1;
          end
        end
      end
      S_DONE, S_ERR: begin
        if (start) begin
          state_d    = S_LEN_HI;
          done_d     = 1'b0;
          error_d    = 1'b0;
          hold_d     = 1'b1;
          xor_d      = '0;
          byte_idx_d = '0;
          word_idx_d = '0;
          part_d     = '0;
        end
      end
      default: begin
        state_d = S_LEN_HI;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_LEN_HI;
      len_hi_q    <= '0;
      len_q       <= '0;
      byte_idx_q  <= '0;
      word_idx_q  <= '0;
      xor_q       <= '0;
      part_q      <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      hold_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      len_hi_q    <= len_hi_d;
      len_q       <= len_d;
      byte_idx_q  <= byte_idx_d;
      word_idx_q  <= word_idx_d;
      xor_q       <= xor_d;
      part_q      <= part_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      done_q      <= done_d;
      error_q     <= error_d;
      hold_q      <= hold_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign done      = done_q;
  assign error     = error_q;
  assign cpu_hold  = hold_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader
//   Drives directed and randomized frames into imem_loader and compares the
//   observed memory writes and status outputs against a frame-level model.
module tb_imem_loader;

  localparam int AW = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;

  int total = 0;
  int bad   = 0;

  logic [63:0] obs_q[$];
  logic [7:0]  frame_q[$];
  logic [63:0] want_q[$];
  logic        want_done;
  logic        want_err;
  int          want_accept;

  imem_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(32'h0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  // Every cycle with the write strobe high is logged once, mid-cycle.
  always @(negedge clk) begin
    if (rst_n && mem_we) obs_q.push_back({mem_addr, mem_wdata});
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  // Presents one byte after an idle gap and holds it until the edge that takes it.
  task automatic applyStimulus(input logic [7:0] b, input int gap);
    int tries;
    repeat (gap) @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    tries    = 0;
    while (!in_ready && tries < 16) begin
      @(negedge clk);
      tries++;
    end
    checkOutput("in_ready_handshake", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic build_frame(input int n, input bit good);
    logic [7:0] x;
    frame_q.delete();
    frame_q.push_back(8'(n >> 8));
    frame_q.push_back(8'(n));
    for (int i = 0; i < 4 * n; i++) frame_q.push_back(8'($urandom));
    x = 8'h00;
    foreach (frame_q[i]) x = x ^ frame_q[i];
    frame_q.push_back(good ? x : (x ^ 8'($urandom_range(1, 255))));
  endtask

  // Frame-level reference: word count, oversize rule, word packing, checksum.
  task automatic compute_model();
    int         n;
    logic [7:0] x;
    want_q.delete();
    n = int'(frame_q[0]) * 256 + int'(frame_q[1]);
    if (n > (1 << AW)) begin
      want_accept = 2;
      want_done   = 1'b0;
      want_err    = 1'b1;
    end else begin
      for (int i = 0; i < n; i++) begin
        want_q.push_back({32'(4 * i), frame_q[2 + 4 * i], frame_q[3 + 4 * i],
                          frame_q[4 + 4 * i], frame_q[5 + 4 * i]});
      end
      x = 8'h00;
      for (int i = 0; i < frame_q.size() - 1; i++) x = x ^ frame_q[i];
      want_accept = frame_q.size();
      want_done   = (frame_q[frame_q.size() - 1] == x);
      want_err    = !want_done;
    end
  endtask

  task automatic run_frame(input string tag, input int maxgap, input bit start_noise);
    int base;
    int nobs;
    base = obs_q.size();
    compute_model();
    for (int i = 0; i < want_accept; i++) begin
      if (start_noise && i == 1) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      applyStimulus(frame_q[i], $urandom_range(0, maxgap));
    end
    repeat (2) @(negedge clk);
    nobs = obs_q.size() - base;
    checkOutput({tag, "_wcount"}, 64'(nobs), 64'(want_q.size()));
    for (int i = 0; i < want_q.size() && i < nobs; i++) begin
      checkOutput({tag, "_write"}, obs_q[base + i], want_q[i]);
    end
    checkOutput({tag, "_done"}, 64'(done), 64'(want_done));
    checkOutput({tag, "_error"}, 64'(error), 64'(want_err));
    checkOutput({tag, "_hold"}, 64'(cpu_hold), 64'(!want_done));
    checkOutput({tag, "_ready"}, 64'(in_ready), 64'd0);
  endtask

  task automatic rearm();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("rearm_done", 64'(done), 64'd0);
    checkOutput("rearm_error", 64'(error), 64'd0);
    checkOutput("rearm_hold", 64'(cpu_hold), 64'd1);
    checkOutput("rearm_ready", 64'(in_ready), 64'd1);
  endtask

  task automatic check_reset_values(input string tag);
    checkOutput({tag, "_ready"}, 64'(in_ready), 64'd1);
    checkOutput({tag, "_we"}, 64'(mem_we), 64'd0);
    checkOutput({tag, "_addr"}, 64'(mem_addr), 64'd0);
    checkOutput({tag, "_wdata"}, 64'(mem_wdata), 64'd0);
    checkOutput({tag, "_hold"}, 64'(cpu_hold), 64'd1);
    checkOutput({tag, "_done"}, 64'(done), 64'd0);
    checkOutput({tag, "_error"}, 64'(error), 64'd0);
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(negedge clk);
    #1;
    check_reset_values("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_values("after_reset");

    $display("[TB] single-word frame");
    frame_q = '{8'h00, 8'h01, 8'h20, 8'h08, 8'h00, 8'h05, 8'h2C};
    run_frame("one_word", 0, 1'b0);
    checkOutput("one_word_data", 64'(mem_wdata), 64'h20080005);
    rearm();

    $display("[TB] two-word frame with gaps");
    build_frame(2, 1'b1);
    run_frame("two_word", 3, 1'b0);
    rearm();

    $display("[TB] bad checksum then recovery");
    frame_q = '{8'h00, 8'h01, 8'h20, 8'h08, 8'h00, 8'h05, 8'hFF};
    run_frame("bad_chk", 1, 1'b0);
    rearm();
    frame_q = '{8'h00, 8'h01, 8'h20, 8'h08, 8'h00, 8'h05, 8'h2C};
    run_frame("recover", 1, 1'b0);
    rearm();

    $display("[TB] empty frames");
    frame_q = '{8'h00, 8'h00, 8'h00};
    run_frame("empty_ok", 0, 1'b0);
    rearm();
    frame_q = '{8'h00, 8'h00, 8'h01};
    run_frame("empty_bad", 0, 1'b0);
    rearm();

    $display("[TB] size limits");
    frame_q = '{8'h01, 8'h01};
    run_frame("oversize", 0, 1'b0);
    rearm();
    build_frame(256, 1'b1);
    run_frame("full_mem", 0, 1'b0);
    rearm();

    $display("[TB] random frames");
    for (int k = 0; k < 8; k++) begin
      build_frame($urandom_range(0, 4), $urandom_range(0, 3) != 0);
      run_frame("random", 3, 1'b1);
      rearm();
    end

    $display("[TB] reset mid-frame");
    build_frame(1, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(frame_q[i], 0);
    rst_n = 1'b0;
    #1;
    check_reset_values("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    build_frame(1, 1'b1);
    run_frame("post_reset", 2, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
